// File: rtl/siren_seq_if.sv
// Control and speaker-side signals of the siren sequencer.
// The master drives the button/switch side. The slave is the siren core.
interface siren_seq_if #(
    parameter int DIV_W     = 20,
    parameter int NUM_TONES = 4,
    parameter int DWELL_W   = 28
);
    logic                         onoff;
    logic                         mode;
    logic [DWELL_W-1:0]           dwell;
    logic [NUM_TONES*DIV_W-1:0]   tone_div;
    logic                         sp;
    logic [3:0]                   tone_idx;
    logic                         step_tick;

    modport master (
        output onoff, mode, dwell, tone_div,
        input  sp, tone_idx, step_tick
    );

    modport slave (
        input  onoff, mode, dwell, tone_div,
        output sp, tone_idx, step_tick
    );
endinterface

// File: rtl/siren_seq.sv
// Multi-tone siren generator: table stepping (mode 0) or triangular sweep (mode 1).
// The speaker square wave only changes divisor at half-period boundaries,
// so every high and low pulse has its full length.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | silent, everything cleared; next enabled cycle loads
// ST_RUN   | dwell timer and tone generator running
module siren_seq #(
    parameter int DIV_W      = 20,
    parameter int NUM_TONES  = 4,
    parameter int DWELL_W    = 28,
    parameter int SWEEP_MIN  = 12500,
    parameter int SWEEP_MAX  = 31250,
    parameter int SWEEP_STEP = 25
) (
    input logic         clk,
    input logic         rst_n,
    siren_seq_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [DIV_W:0]   MIN_X  = (DIV_W+1)'(SWEEP_MIN);
    localparam logic [DIV_W:0]   MAX_X  = (DIV_W+1)'(SWEEP_MAX);
    localparam logic [DIV_W:0]   STEP_X = (DIV_W+1)'(SWEEP_STEP);
    localparam logic [DIV_W-1:0] MAX_D  = DIV_W'(SWEEP_MAX);
    localparam logic [DIV_W-1:0] MIN_D  = DIV_W'(SWEEP_MIN);
    localparam logic [3:0]       LAST_IDX = 4'(NUM_TONES - 1);

    logic [0:0]         state_q, state_d;
    logic               mode_q, mode_d;
    logic               sp_q, sp_d;
    logic               step_tick_q, step_tick_d;
    logic [3:0]         tone_idx_q, tone_idx_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [DIV_W-1:0]   tone_cnt_q, tone_cnt_d;
    logic [DIV_W-1:0]   active_div_q, active_div_d;
    logic [DIV_W-1:0]   sweep_div_q, sweep_div_d;
    logic               sweep_up_q, sweep_up_d;

    logic [DWELL_W-1:0] dwell_term;
    logic [DIV_W:0]     sweep_ext;
    logic [DIV_W-1:0]   target;

    function automatic logic [DIV_W-1:0] table_entry(
        input logic [NUM_TONES*DIV_W-1:0] tbl,
        input logic [3:0]                 idx
    );
        logic [DIV_W-1:0] e;
        e = '0;
        for (int i = 0; i < NUM_TONES; i++) begin
            if (idx == 4'(i)) e = tbl[i*DIV_W +: DIV_W];
        end
        return e;
    endfunction

    // Next-state: restart handling, dwell timer, sequencing and tone generation
    always_comb begin
        state_d      = state_q;
        mode_d       = bus.mode;
        sp_d         = sp_q;
        step_tick_d  = 1'b0;
        tone_idx_d   = tone_idx_q;
        dwell_cnt_d  = dwell_cnt_q;
        tone_cnt_d   = tone_cnt_q;
        active_div_d = active_div_q;
        sweep_div_d  = sweep_div_q;
        sweep_up_d   = sweep_up_q;
        target       = '0;
        sweep_ext    = {1'b0, sweep_div_q};
        // dwell of 0 behaves as 1: terminal count 0 either way
        dwell_term   = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;

        if (!bus.onoff || state_q == ST_IDLE || bus.mode != mode_q) begin
            // Common cleared state for silence and for the restart/load cycle
            state_d      = bus.onoff ? ST_RUN : ST_IDLE;
            sp_d         = 1'b0;
            tone_idx_d   = '0;
            dwell_cnt_d  = '0;
            tone_cnt_d   = '0;
            sweep_div_d  = MAX_D;
            sweep_up_d   = 1'b0;
            active_div_d = '0;
            if (bus.onoff) begin
                active_div_d = bus.mode ? MAX_D : table_entry(bus.tone_div, 4'd0);
            end
        end else begin
            if (dwell_cnt_q >= dwell_term) begin
                step_tick_d = 1'b1;
                dwell_cnt_d = '0;
                if (!bus.mode) begin
                    tone_idx_d = (tone_idx_q == LAST_IDX) ? 4'd0 : tone_idx_q + 4'd1;
                end else if (!sweep_up_q) begin
                    // compare before subtracting so a small divisor never wraps
                    if (sweep_ext <= MIN_X + STEP_X) begin
                        sweep_div_d = MIN_D;
                        sweep_up_d  = 1'b1;
                    end else begin
                        sweep_div_d = sweep_div_q - DIV_W'(SWEEP_STEP);
                    end
                end else begin
                    if (sweep_ext + STEP_X >= MAX_X) begin
                        sweep_div_d = MAX_D;
                        sweep_up_d  = 1'b0;
                    end else begin
                        sweep_div_d = sweep_div_q + DIV_W'(SWEEP_STEP);
                    end
                end
            end else begin
                dwell_cnt_d = dwell_cnt_q + 1'b1;
            end

            // A step on this cycle already selects the divisor for the next half-period
            target = bus.mode ? sweep_div_d : table_entry(bus.tone_div, tone_idx_d);

            if (active_div_q == '0) begin
                sp_d         = 1'b0;
                tone_cnt_d   = '0;
                active_div_d = target;
            end else if (tone_cnt_q == active_div_q - 1'b1) begin
                tone_cnt_d   = '0;
                active_div_d = target;
                // entering a rest ends the tone low instead of leaving a runt high
                sp_d         = (target == '0) ? 1'b0 : ~sp_q;
            end else begin
                tone_cnt_d   = tone_cnt_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= 1'b0;
            sp_q         <= 1'b0;
            step_tick_q  <= 1'b0;
            tone_idx_q   <= '0;
            dwell_cnt_q  <= '0;
            tone_cnt_q   <= '0;
            active_div_q <= '0;
            sweep_div_q  <= MAX_D;
            sweep_up_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            sp_q         <= sp_d;
            step_tick_q  <= step_tick_d;
            tone_idx_q   <= tone_idx_d;
            dwell_cnt_q  <= dwell_cnt_d;
            tone_cnt_q   <= tone_cnt_d;
            active_div_q <= active_div_d;
            sweep_div_q  <= sweep_div_d;
            sweep_up_q   <= sweep_up_d;
        end
    end

    assign bus.sp        = sp_q;
    assign bus.tone_idx  = tone_idx_q;
    assign bus.step_tick = step_tick_q;

endmodule
